// File: rtl/updown_pulse_gen.sv
// Command-driven up/down strobe generator with a shadow copy of the downstream counter.
// Optional saturation (no wrap, err pulse instead) is enabled by defining UPDOWN_PULSE_GEN_SAT_EN.
module updown_pulse_gen #(
    parameter int WIDTH   = 20,
    parameter int DELTA_W = 16,
    parameter int GAP_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DELTA_W-1:0] cmd_delta,
    input  logic [GAP_W-1:0]   cmd_gap,
    input  logic               abort,
    output logic               up,
    output logic               down,
    output logic               busy,
    output logic               done,
`ifdef UPDOWN_PULSE_GEN_SAT_EN
    output logic               err,
`endif
    output logic [WIDTH-1:0]   shadow
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t             state, state_nx;
    logic               dir_dn, dir_dn_nx;
    logic [DELTA_W-1:0] remaining, remaining_nx;
    logic [GAP_W-1:0]   gap, gap_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
    logic               up_nx, down_nx, done_nx;
    logic [WIDTH-1:0]   shadow_nx;
    logic               issue, issue_dn;
`ifdef UPDOWN_PULSE_GEN_SAT_EN
    logic               sat_stop, sat_stop_nx;
    logic               err_nx;
`endif

    assign cmd_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir_dn    <= 1'b0;
            remaining <= '0;
            gap       <= '0;
            gap_cnt   <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shadow    <= '0;
`ifdef UPDOWN_PULSE_GEN_SAT_EN
            sat_stop  <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            dir_dn    <= dir_dn_nx;
            remaining <= remaining_nx;
            gap       <= gap_nx;
            gap_cnt   <= gap_cnt_nx;
            up        <= up_nx;
            down      <= down_nx;
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            shadow    <= shadow_nx;
`ifdef UPDOWN_PULSE_GEN_SAT_EN
            sat_stop  <= sat_stop_nx;
            err       <= err_nx;
`endif
        end
    end

    // A pulse is issued on the edge that enters PULSE, so the strobe and
    // the shadow update become visible together in the PULSE cycle.
    always_comb begin
        state_nx     = state;
        dir_dn_nx    = dir_dn;
        remaining_nx = remaining;
        gap_nx       = gap;
        gap_cnt_nx   = gap_cnt;
        up_nx        = 1'b0;
        down_nx      = 1'b0;
        done_nx      = 1'b0;
        shadow_nx    = shadow;
        issue        = 1'b0;
        issue_dn     = dir_dn;
`ifdef UPDOWN_PULSE_GEN_SAT_EN
        sat_stop_nx  = 1'b0;
        err_nx       = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    gap_nx = cmd_gap;
                    if (cmd_delta == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        dir_dn_nx    = cmd_delta[DELTA_W-1];
                        remaining_nx = cmd_delta[DELTA_W-1] ? (~cmd_delta + 1'b1) : cmd_delta;
                        issue        = 1'b1;
                        issue_dn     = cmd_delta[DELTA_W-1];
                    end
                end
            end
            PULSE: begin
`ifdef UPDOWN_PULSE_GEN_SAT_EN
                if (sat_stop) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else
`endif
                begin
                    remaining_nx = remaining - 1'b1;
                    if (remaining == 1) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else if (gap == '0) begin
                        issue = 1'b1;
                    end else begin
                        state_nx   = GAP;
                        gap_cnt_nx = gap;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 1) begin
                    issue = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A suppressed pulse still occupies its PULSE cycle; the command ends after it.
        if (issue) begin
            state_nx = PULSE;
`ifdef UPDOWN_PULSE_GEN_SAT_EN
            if (issue_dn ? (shadow == '0) : (&shadow)) begin
                sat_stop_nx = 1'b1;
            end else
`endif
            begin
                up_nx     = !issue_dn;
                down_nx   = issue_dn;
                shadow_nx = issue_dn ? (shadow - 1'b1) : (shadow + 1'b1);
            end
        end

        if (abort && (state != IDLE)) begin
            state_nx  = IDLE;
            up_nx     = 1'b0;
            down_nx   = 1'b0;
            done_nx   = 1'b0;
            shadow_nx = shadow;
`ifdef UPDOWN_PULSE_GEN_SAT_EN
            sat_stop_nx = 1'b0;
            err_nx      = 1'b0;
`endif
        end
    end

endmodule
